// File: rtl/grf_writeback_pkg.sv
// rtl/grf_writeback_pkg.sv - shared widths and writeback/load-type codes for the W stage
package grf_writeback_pkg;

  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int ADDR_W = $clog2(NREG);

  // Code 3 is reserved and falls through to the ALU result.
  typedef enum logic [1:0] {
    M2R_AO   = 2'd0,
    M2R_DM   = 2'd1,
    M2R_LINK = 2'd2,
    M2R_RSVD = 2'd3
  } mem2reg_e;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } ld_type_e;

endpackage

// File: rtl/grf_writeback_if.sv
// rtl/grf_writeback_if.sv - W-stage inputs, D-stage read ports and forwarding outputs of the GRF
interface grf_writeback_if;
  import grf_writeback_pkg::*;

  logic                RegWE;
  logic [1:0]          Mem2Reg;
  logic [ADDR_W-1:0]   A3_W;
  logic [DATA_W-1:0]   AO_W;
  logic [DATA_W-1:0]   DR_W;
  logic [DATA_W-1:0]   PC8_W;
  logic [1:0]          ByteOff_W;
  logic [2:0]          LdType_W;
  logic [ADDR_W-1:0]   A1;
  logic [ADDR_W-1:0]   A2;
  logic [DATA_W-1:0]   RD1;
  logic [DATA_W-1:0]   RD2;
  logic [DATA_W-1:0]   WD_W;
  logic                WE_eff;

  modport master (
    output RegWE, Mem2Reg, A3_W, AO_W, DR_W, PC8_W, ByteOff_W, LdType_W, A1, A2,
    input  RD1, RD2, WD_W, WE_eff
  );

  modport slave (
    input  RegWE, Mem2Reg, A3_W, AO_W, DR_W, PC8_W, ByteOff_W, LdType_W, A1, A2,
    output RD1, RD2, WD_W, WE_eff
  );

endinterface

// File: rtl/grf_writeback_load_ext.sv
// rtl/grf_writeback_load_ext.sv - picks the loaded byte/halfword out of the aligned word and extends it
module grf_writeback_load_ext
  import grf_writeback_pkg::*;
(
  input  logic [DATA_W-1:0] dr,
  input  logic [1:0]        byte_off,
  input  logic [2:0]        ld_type,
  output logic [DATA_W-1:0] ext
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  // Halfword lanes ignore byte_off[0]; misaligned lh is not trapped here.
  assign sel_b = 8'(dr >> {byte_off, 3'b000});
  assign sel_h = 16'(dr >> {byte_off[1], 4'b0000});

  always_comb begin
    ext = dr;
    case (ld_type)
      LD_B:    ext = {{(DATA_W-8){sel_b[7]}}, sel_b};
      LD_BU:   ext = {{(DATA_W-8){1'b0}}, sel_b};
      LD_H:    ext = {{(DATA_W-16){sel_h[15]}}, sel_h};
      LD_HU:   ext = {{(DATA_W-16){1'b0}}, sel_h};
      default: ext = dr;
    endcase
  end

endmodule

// File: rtl/grf_writeback.sv
// rtl/grf_writeback.sv - W-stage writeback select plus 32x32 register file with write-first read bypass
module grf_writeback
  import grf_writeback_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  grf_writeback_if.slave   wb
);

  logic [DATA_W-1:0] grf_q [NREG];
  logic [DATA_W-1:0] grf_d [NREG];
  logic [DATA_W-1:0] ld_ext;
  logic [DATA_W-1:0] wd;
  logic              we_eff;

  grf_writeback_load_ext u_load_ext (
    .dr       (wb.DR_W),
    .byte_off (wb.ByteOff_W),
    .ld_type  (wb.LdType_W),
    .ext      (ld_ext)
  );

  always_comb begin
    case (wb.Mem2Reg)
      M2R_DM:   wd = ld_ext;
      M2R_LINK: wd = wb.PC8_W;
      default:  wd = wb.AO_W;
    endcase
  end

  // Qualified by reset so nothing is bypassed or written while the file is held clear.
  assign we_eff = reset && wb.RegWE && (wb.A3_W != '0);

  always_comb begin
    grf_d = grf_q;
    if (we_eff) begin
      grf_d[wb.A3_W] = wd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        grf_q[i] <= '0;
      end
    end else begin
      grf_q <= grf_d;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if (addr == '0) begin
      return '0;
    end else if (we_eff && (addr == wb.A3_W)) begin
      return wd;
    end
    return grf_q[addr];
  endfunction

  assign wb.RD1    = read_port(wb.A1);
  assign wb.RD2    = read_port(wb.A2);
  assign wb.WD_W   = wd;
  assign wb.WE_eff = we_eff;

endmodule

// File: tb/tb_grf_writeback.sv
// tb/tb_grf_writeback.sv - directed and randomized checks of grf_writeback against a register-file model
module tb_grf_writeback;

  logic clk;
  logic reset;
  logic cmp_en;
  int   n_pass;
  int   n_total;

  logic [31:0] model [32];

  grf_writeback_if wb ();

  grf_writeback dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Writeback value from the architectural rules: shift the wanted lane down, mask, extend.
  function automatic logic [31:0] m_wd(input logic [1:0] m2r, input logic [31:0] ao,
                                       input logic [31:0] dr, input logic [31:0] pc8,
                                       input logic [1:0] off, input logic [2:0] ld);
    logic [31:0] v;
    if (m2r == 2'd2) return pc8;
    if (m2r != 2'd1) return ao;
    case (ld)
      3'd1, 3'd2: begin
        v = (dr >> (8 * int'(off))) & 32'hFF;
        if (ld == 3'd1 && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
      3'd3, 3'd4: begin
        v = (dr >> (16 * (int'(off) / 2))) & 32'hFFFF;
        if (ld == 3'd3 && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      default: v = dr;
    endcase
    return v;
  endfunction

  function automatic logic m_we();
    return reset && wb.RegWE && (wb.A3_W != 5'd0);
  endfunction

  function automatic logic [31:0] m_cur_wd();
    return m_wd(wb.Mem2Reg, wb.AO_W, wb.DR_W, wb.PC8_W, wb.ByteOff_W, wb.LdType_W);
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_we() && a == wb.A3_W) return m_cur_wd();
    return model[a];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) model[i] <= 32'd0;
    end else if (m_we()) begin
      model[wb.A3_W] <= m_cur_wd();
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_rd1",  wb.RD1,          m_rd(wb.A1));
      check("cyc_rd2",  wb.RD2,          m_rd(wb.A2));
      check("cyc_wd",   wb.WD_W,         m_cur_wd());
      check("cyc_we",   32'(wb.WE_eff),  32'(m_we()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, 31));
  endfunction

  typedef struct {
    logic [1:0]  off;
    logic [2:0]  ld;
    logic [31:0] exp;
  } ext_case_t;

  ext_case_t ext_tab [6];

  initial begin
    n_pass  = 0;
    n_total = 0;
    cmp_en  = 1'b0;
    reset   = 1'b1;
    wb.RegWE = 1'b0; wb.Mem2Reg = 2'd0; wb.A3_W = 5'd0; wb.AO_W = '0;
    wb.DR_W = '0; wb.PC8_W = '0; wb.ByteOff_W = 2'd0; wb.LdType_W = 3'd0;
    wb.A1 = 5'd0; wb.A2 = 5'd0;
    #2 reset = 1'b0;
    #1;
    check("reset_rd1", wb.RD1, 32'd0);
    check("reset_we",  32'(wb.WE_eff), 32'd0);
    step();
    reset = 1'b1;
    step();
    cmp_en = 1'b1;

    // Reset clears asynchronously and blocks writes while low.
    wb.RegWE = 1'b1; wb.A3_W = 5'd5; wb.AO_W = 32'h1234;
    step();
    wb.RegWE = 1'b0; wb.A1 = 5'd5;
    #1 check("t1_written", wb.RD1, 32'h1234);
    reset = 1'b0;
    #1 check("t1_async_clear", wb.RD1, 32'd0);
    wb.RegWE = 1'b1; wb.AO_W = 32'h55;
    step();
    check("t1_blocked", wb.RD1, 32'd0);
    check("t1_we_low", 32'(wb.WE_eff), 32'd0);
    reset = 1'b1; wb.RegWE = 1'b0;
    #1 check("t1_after_release", wb.RD1, 32'd0);
    step();

    // $0 is never written.
    wb.RegWE = 1'b1; wb.A3_W = 5'd0; wb.AO_W = 32'hFFFF_FFFF; wb.A1 = 5'd0;
    #1 check("t2_rd1_same", wb.RD1, 32'd0);
    check("t2_we", 32'(wb.WE_eff), 32'd0);
    step();
    wb.RegWE = 1'b0;
    #1 check("t2_rd1_after", wb.RD1, 32'd0);

    // Load extension.
    ext_tab[0] = '{2'd3, 3'd1, 32'hFFFF_FF80};
    ext_tab[1] = '{2'd3, 3'd2, 32'h0000_0080};
    ext_tab[2] = '{2'd1, 3'd1, 32'h0000_007F};
    ext_tab[3] = '{2'd2, 3'd3, 32'hFFFF_80F1};
    ext_tab[4] = '{2'd0, 3'd4, 32'h0000_7F02};
    ext_tab[5] = '{2'd1, 3'd3, 32'h0000_7F02};
    wb.Mem2Reg = 2'd1; wb.DR_W = 32'h80F1_7F02;
    for (int i = 0; i < 6; i++) begin
      wb.ByteOff_W = ext_tab[i].off; wb.LdType_W = ext_tab[i].ld;
      #1 check($sformatf("t3_ext%0d", i), wb.WD_W, ext_tab[i].exp);
      check($sformatf("t3_model%0d", i),
            m_wd(2'd1, 32'd0, 32'h80F1_7F02, 32'd0, ext_tab[i].off, ext_tab[i].ld), ext_tab[i].exp);
    end
    step();

    // Same-cycle bypass on both ports.
    wb.Mem2Reg = 2'd0; wb.RegWE = 1'b1; wb.A3_W = 5'd8; wb.AO_W = 32'hDEAD_BEEF;
    wb.A1 = 5'd8; wb.A2 = 5'd8;
    #1 check("t4_rd1_bypass", wb.RD1, 32'hDEAD_BEEF);
    check("t4_rd2_bypass", wb.RD2, 32'hDEAD_BEEF);
    step();
    wb.RegWE = 1'b0; wb.AO_W = 32'd0;
    #1 check("t4_stored", wb.RD1, 32'hDEAD_BEEF);

    // Link write.
    wb.Mem2Reg = 2'd2; wb.PC8_W = 32'h0000_3008; wb.A3_W = 5'd31; wb.RegWE = 1'b1;
    step();
    wb.RegWE = 1'b0; wb.A2 = 5'd31;
    #1 check("t5_link", wb.RD2, 32'h0000_3008);

    // Back-to-back writes.
    wb.Mem2Reg = 2'd0; wb.RegWE = 1'b1; wb.A3_W = 5'd9; wb.AO_W = 32'd1; wb.A1 = 5'd9;
    #1 check("t6_first", wb.RD1, 32'd1);
    step();
    wb.AO_W = 32'd2;
    #1 check("t6_second", wb.RD1, 32'd2);
    step();
    wb.RegWE = 1'b0;
    #1 check("t6_hold0", wb.RD1, 32'd2);
    step();
    step();
    check("t6_hold2", wb.RD1, 32'd2);

    // Randomized traffic, including occasional asynchronous reset pulses.
    for (int n = 0; n < 600; n++) begin
      reset        = ($urandom_range(0, 39) != 0);
      wb.RegWE     = 1'($urandom_range(0, 3) != 0);
      wb.Mem2Reg   = 2'($urandom_range(0, 3));
      wb.A3_W      = pick_reg();
      wb.A1        = pick_reg();
      wb.A2        = pick_reg();
      wb.AO_W      = $urandom;
      wb.DR_W      = $urandom;
      wb.PC8_W     = $urandom;
      wb.ByteOff_W = 2'($urandom_range(0, 3));
      wb.LdType_W  = 3'($urandom_range(0, 7));
      step();
    end
    reset = 1'b1;
    wb.RegWE = 1'b0;
    step();
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
